sync_mem_clr: RTL

Parametrised, clocked successor to the team's 256x8 combinational memory: a single-port synchronous RAM with registered read data, a read-valid strobe, and a hardware clear sequencer. The sequencer zeroes every location after reset and on request. It sits behind any master that issues single-cycle rd/wr strobes. Depth and width are set by parameters.

---
 rtl/sync_mem_clr.sv | 73 +++++++
 1 files changed

// File: rtl/sync_mem_clr.sv
// sync_mem_clr: single-port synchronous RAM with registered read data and a clear sequencer
// that zeroes every location after reset and on request.
module sync_mem_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic dout_valid_q, dout_valid_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    always_comb begin
        state_d = state_q;
        clr_cnt_d = clr_cnt_q;
        dout_d = dout_q;
        dout_valid_d = 1'b0;
        mem_we = 1'b0;
        mem_addr = addr;
        mem_wdata = din;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
            mem_addr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (&clr_cnt_q) state_d = IDLE;
        end else if (clr) begin
            state_d = CLEAR;
            clr_cnt_d = '0;
        end else begin
            mem_we = wr;
            if (rd) begin
                // write-first: a same-edge write is what the read returns
                dout_d = wr ? din : mem[addr];
                dout_valid_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            clr_cnt_q <= '0;
            dout_q <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_cnt_q <= clr_cnt_d;
            dout_q <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end
    // the array itself has no reset; the sequencer defines its contents
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign dout = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy = (state_q == CLEAR);
endmodule
